ssp1_scan_sequencer: RTL and testbench

Sequences the superswitch chips' scan interface from command/data streams. It accepts one command at a time (reset, address-chain write or instruction-chain write) with a 4-bit chip mask. It then generates the divided scan clock, shifts one column of bits per scan-clock period into the instruction chains or the address chain, and finishes with an update pulse. It sits between the UART command decoder inside `ssp1_controller` and the chip-facing scan pins.

---
 rtl/ssp1_pkg.sv | 24 ++
 rtl/ssp1_scan_phase_timer.sv | 28 ++
 rtl/ssp1_scan_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_ssp1_scan_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp1_pkg.sv
`timescale 1ns/1ps
// Shared types for the SSP1 scan sequencer: command opcodes and FSM states.
package ssp1_pkg;

  localparam int NumChips = 4;

  typedef enum logic [1:0] {
    OP_RESET      = 2'd0,
    OP_WRITE_ADDR = 2'd1,
    OP_WRITE_INST = 2'd2,
    OP_NOP        = 2'd3
  } scan_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_FETCH  = 3'd2,
    ST_LO     = 3'd3,
    ST_HI     = 3'd4,
    ST_UPDATE = 3'd5,
    ST_DONE   = 3'd6
  } scan_state_t;

endpackage

// File: rtl/ssp1_scan_phase_timer.sv
`timescale 1ns/1ps
// Loadable down-counter timing the scan phases; o_expire marks the last
// cycle of the loaded duration.
module ssp1_scan_phase_timer #(
  parameter int Width = 5
) (
  input  logic             i_sys_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  output logic             o_expire
);

  logic [Width-1:0] count_q;

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (i_load) begin
      count_q <= i_load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign o_expire = (count_q == Width'(1));

endmodule

// File: rtl/ssp1_scan_sequencer.sv
`timescale 1ns/1ps
// Scan-chain sequencer: turns one command plus a stream of bit columns into
// divided scan clock, per-chip enables, shift data and update/reset pulses.
module ssp1_scan_sequencer
  import ssp1_pkg::*;
#(
  parameter int NumInstChains      = 8,
  parameter int InstChainLength    = 64,
  parameter int AddressChainLength = 16,
  parameter int ScanClkDiv         = 4
) (
  input  logic                     i_sys_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [1:0]               i_cmd_op,
  input  logic [3:0]               i_cmd_chip_mask,
  input  logic                     i_bit_valid,
  output logic                     o_bit_ready,
  input  logic [NumInstChains-1:0] i_bit_data,
  output logic                     o_scan_clk,
  output logic [3:0]               o_scan_reset,
  output logic [3:0]               o_scan_update,
  output logic [3:0]               o_scan_en_inst,
  output logic [NumInstChains-1:0] o_scan_in_inst,
  output logic [3:0]               o_scan_en_address,
  output logic                     o_scan_in_address,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int MaxLen = (InstChainLength > AddressChainLength) ? InstChainLength
                                                                 : AddressChainLength;
  localparam int CntW   = $clog2(MaxLen + 1);
  localparam int TmrW   = $clog2(4 * ScanClkDiv + 1);

  localparam logic [CntW-1:0] InstLast  = CntW'(InstChainLength - 1);
  localparam logic [CntW-1:0] AddrLast  = CntW'(AddressChainLength - 1);
  localparam logic [TmrW-1:0] PhaseTick = TmrW'(ScanClkDiv);
  localparam logic [TmrW-1:0] UpdTick   = TmrW'(2 * ScanClkDiv);
  localparam logic [TmrW-1:0] RstTick   = TmrW'(4 * ScanClkDiv);

  scan_state_t state_q, state_n;
  scan_op_t    op_q, op_n;
  logic [3:0]      mask_q, mask_n;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_n;
  logic [CntW-1:0] last_idx;
  logic [TmrW-1:0] tmr_val;
  logic            tmr_load, tmr_expire;
  logic            accept, bit_take;

  logic                     cmd_ready_q, cmd_ready_n;
  logic                     bit_ready_q, bit_ready_n;
  logic                     scan_clk_q, scan_clk_n;
  logic [3:0]               scan_reset_q, scan_reset_n;
  logic [3:0]               scan_update_q, scan_update_n;
  logic [3:0]               en_inst_q, en_inst_n;
  logic [3:0]               en_addr_q, en_addr_n;
  logic [NumInstChains-1:0] inst_hold_q, inst_hold_n;
  logic                     addr_hold_q, addr_hold_n;
  logic                     busy_q, busy_n;
  logic                     done_q, done_n;

  assign accept   = i_cmd_valid && cmd_ready_q;
  assign bit_take = i_bit_valid && bit_ready_q;
  assign last_idx = (op_q == OP_WRITE_INST) ? InstLast : AddrLast;

  ssp1_scan_phase_timer #(.Width(TmrW)) u_phase_timer (
    .i_sys_clk  (i_sys_clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_expire   (tmr_expire)
  );

  always_comb begin
    state_n   = state_q;
    op_n      = op_q;
    mask_n    = mask_q;
    bit_cnt_n = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_n      = scan_op_t'(i_cmd_op);
          mask_n    = i_cmd_chip_mask;
          bit_cnt_n = '0;
          if (i_cmd_chip_mask == 4'b0 || scan_op_t'(i_cmd_op) == OP_NOP) begin
            state_n = ST_DONE;
          end else if (scan_op_t'(i_cmd_op) == OP_RESET) begin
            state_n = ST_RESET;
          end else begin
            state_n = ST_FETCH;
          end
        end
      end
      ST_RESET:  if (tmr_expire) state_n = ST_DONE;
      ST_FETCH:  if (bit_take)   state_n = ST_LO;
      ST_LO:     if (tmr_expire) state_n = ST_HI;
      ST_HI: begin
        if (tmr_expire) begin
          bit_cnt_n = bit_cnt_q + CntW'(1);
          state_n   = (bit_cnt_q == last_idx) ? ST_UPDATE : ST_FETCH;
        end
      end
      ST_UPDATE: if (tmr_expire) state_n = ST_DONE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase

    // Every timed state is (re)loaded on entry.
    tmr_load = (state_n != state_q);
    case (state_n)
      ST_RESET:     tmr_val = RstTick;
      ST_LO, ST_HI: tmr_val = PhaseTick;
      ST_UPDATE:    tmr_val = UpdTick;
      default:      tmr_val = '0;
    endcase

    // Outputs are decoded from the next state so every pin is a flop that
    // lines up exactly with the state register.
    cmd_ready_n   = (state_n == ST_IDLE);
    bit_ready_n   = (state_n == ST_FETCH);
    busy_n        = (state_n != ST_IDLE);
    done_n        = (state_n == ST_DONE);
    scan_clk_n    = (state_n == ST_HI);
    scan_reset_n  = (state_n == ST_RESET)  ? mask_n : 4'b0;
    scan_update_n = (state_n == ST_UPDATE) ? mask_n : 4'b0;

    // Enables rise at the first LO and hold through inter-bit FETCH stalls.
    case (state_n)
      ST_LO: begin
        en_inst_n = (op_n == OP_WRITE_INST) ? mask_n : 4'b0;
        en_addr_n = (op_n == OP_WRITE_ADDR) ? mask_n : 4'b0;
      end
      ST_FETCH, ST_HI: begin
        en_inst_n = en_inst_q;
        en_addr_n = en_addr_q;
      end
      default: begin
        en_inst_n = 4'b0;
        en_addr_n = 4'b0;
      end
    endcase

    inst_hold_n = inst_hold_q;
    addr_hold_n = addr_hold_q;
    if (bit_take && op_q == OP_WRITE_INST) inst_hold_n = i_bit_data;
    if (bit_take && op_q == OP_WRITE_ADDR) addr_hold_n = i_bit_data[0];
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_NOP;
      mask_q        <= 4'b0;
      bit_cnt_q     <= '0;
      cmd_ready_q   <= 1'b0;
      bit_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      scan_clk_q    <= 1'b0;
      scan_reset_q  <= 4'b0;
      scan_update_q <= 4'b0;
      en_inst_q     <= 4'b0;
      en_addr_q     <= 4'b0;
      inst_hold_q   <= '0;
      addr_hold_q   <= 1'b0;
    end else begin
      state_q       <= state_n;
      op_q          <= op_n;
      mask_q        <= mask_n;
      bit_cnt_q     <= bit_cnt_n;
      cmd_ready_q   <= cmd_ready_n;
      bit_ready_q   <= bit_ready_n;
      busy_q        <= busy_n;
      done_q        <= done_n;
      scan_clk_q    <= scan_clk_n;
      scan_reset_q  <= scan_reset_n;
      scan_update_q <= scan_update_n;
      en_inst_q     <= en_inst_n;
      en_addr_q     <= en_addr_n;
      inst_hold_q   <= inst_hold_n;
      addr_hold_q   <= addr_hold_n;
    end
  end

  assign o_cmd_ready       = cmd_ready_q;
  assign o_bit_ready       = bit_ready_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_scan_clk        = scan_clk_q;
  assign o_scan_reset      = scan_reset_q;
  assign o_scan_update     = scan_update_q;
  assign o_scan_en_inst    = en_inst_q;
  assign o_scan_en_address = en_addr_q;
  assign o_scan_in_inst    = inst_hold_q;
  assign o_scan_in_address = addr_hold_q;

endmodule

// File: tb/tb_ssp1_scan_sequencer.sv
`timescale 1ns/1ps
// Directed bench for ssp1_scan_sequencer with default parameters
// (8 chains, 64-bit instruction chain, 16-bit address chain, divider 4).
module tb_ssp1_scan_sequencer;

  localparam int NIC = 8;
  localparam int DIV = 4;

  logic           i_sys_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_cmd_valid = 1'b0;
  logic           o_cmd_ready;
  logic [1:0]     i_cmd_op = 2'd3;
  logic [3:0]     i_cmd_chip_mask = 4'b0;
  logic           i_bit_valid = 1'b0;
  logic           o_bit_ready;
  logic [NIC-1:0] i_bit_data = '0;
  logic           o_scan_clk;
  logic [3:0]     o_scan_reset, o_scan_update, o_scan_en_inst, o_scan_en_address;
  logic [NIC-1:0] o_scan_in_inst;
  logic           o_scan_in_address, o_busy, o_done;

  ssp1_scan_sequencer dut (
    .i_sys_clk         (i_sys_clk),
    .i_rst             (i_rst),
    .i_cmd_valid       (i_cmd_valid),
    .o_cmd_ready       (o_cmd_ready),
    .i_cmd_op          (i_cmd_op),
    .i_cmd_chip_mask   (i_cmd_chip_mask),
    .i_bit_valid       (i_bit_valid),
    .o_bit_ready       (o_bit_ready),
    .i_bit_data        (i_bit_data),
    .o_scan_clk        (o_scan_clk),
    .o_scan_reset      (o_scan_reset),
    .o_scan_update     (o_scan_update),
    .o_scan_en_inst    (o_scan_en_inst),
    .o_scan_in_inst    (o_scan_in_inst),
    .o_scan_en_address (o_scan_en_address),
    .o_scan_in_address (o_scan_in_address),
    .o_busy            (o_busy),
    .o_done            (o_done)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  int total = 0;
  int bad = 0;

  // per-command observation counters
  int cyc = 0, rises = 0, setup_bad = 0, hold_bad = 0, last_rise = -100, last_chg = 0;
  int upd_hit = 0, upd_any = 0, upd_last = 0, rst_hit = 0, rst_any = 0;
  int en_bad = 0, en_upd_bad = 0, done_cnt = 0, done_cyc = 0, busy_ready = 0;
  int stall_cyc = 0, gap_clk_bad = 0, stall_en_bad = 0;
  logic [3:0] exp_mask = 4'b0, exp_en_inst = 4'b0, exp_en_addr = 4'b0;
  logic           prev_clk = 1'b0;
  logic [NIC:0]   prev_data = '0;
  logic           hs = 1'b0;
  logic [NIC-1:0] rise_inst[$];
  logic           rise_addr[$];

  int col, taken, gap, mis;
  logic [15:0] addr_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [28:0] pins();
    return {o_scan_clk, o_scan_reset, o_scan_update, o_scan_en_inst, o_scan_in_inst,
            o_scan_en_address, o_scan_in_address, o_busy, o_done, o_bit_ready};
  endfunction

  task automatic clr_stats();
    cyc = 1; rises = 0; setup_bad = 0; hold_bad = 0; last_rise = -100; last_chg = 1;
    upd_hit = 0; upd_any = 0; upd_last = 0; rst_hit = 0; rst_any = 0;
    en_bad = 0; en_upd_bad = 0; done_cnt = 0; done_cyc = 0; busy_ready = 0;
    stall_cyc = 0; gap_clk_bad = 0; stall_en_bad = 0;
    prev_clk = o_scan_clk;
    prev_data = {o_scan_in_inst, o_scan_in_address};
    rise_inst.delete();
    rise_addr.delete();
  endtask

  // One clock: note the handshake/stall seen before the edge, then sample #1 after it.
  task automatic tick();
    hs = o_bit_ready && i_bit_valid;
    if (o_bit_ready && !i_bit_valid) begin
      stall_cyc++;
      if (o_scan_clk) gap_clk_bad++;
      if (o_scan_en_inst !== exp_en_inst || o_scan_en_address !== exp_en_addr) stall_en_bad++;
    end
    @(posedge i_sys_clk);
    #1;
    cyc++;
    if (o_scan_clk && !prev_clk) begin
      rise_inst.push_back(o_scan_in_inst);
      rise_addr.push_back(o_scan_in_address);
      if (cyc - last_chg < DIV) setup_bad++;
      last_rise = cyc;
      rises++;
    end
    if ({o_scan_in_inst, o_scan_in_address} !== prev_data) begin
      if (cyc - last_rise < DIV) hold_bad++;
      last_chg = cyc;
    end
    prev_clk  = o_scan_clk;
    prev_data = {o_scan_in_inst, o_scan_in_address};
    if (o_scan_update != 4'b0) begin upd_any++; upd_last = cyc; end
    if (o_scan_update === exp_mask) upd_hit++;
    if (o_scan_update != 4'b0 && (o_scan_en_inst | o_scan_en_address) != 4'b0) en_upd_bad++;
    if (o_scan_reset != 4'b0) rst_any++;
    if (o_scan_reset === exp_mask) rst_hit++;
    if (o_scan_clk && (o_scan_en_inst !== exp_en_inst || o_scan_en_address !== exp_en_addr))
      en_bad++;
    if (o_done) begin done_cnt++; done_cyc = cyc; end
    if (o_busy && o_cmd_ready) busy_ready++;
  endtask

  initial begin
    // ---------------- reset ----------------
    tick();
    tick();
    chk("reset_pins_during", 64'(pins()), 64'h0);
    chk("reset_cmd_ready_during", 64'(o_cmd_ready), 64'h0);
    i_rst = 1'b0;
    tick();
    chk("reset_pins_after", 64'(pins()), 64'h0);
    chk("reset_cmd_ready_after", 64'(o_cmd_ready), 64'h1);
    chk("reset_busy_after", 64'(o_busy), 64'h0);

    // ---------------- WRITE_INST mask 0101, columns 0x00..0x3F ----------------
    i_cmd_valid = 1'b1; i_cmd_op = 2'd2; i_cmd_chip_mask = 4'b0101;
    exp_mask = 4'b0101; exp_en_inst = 4'b0101; exp_en_addr = 4'b0;
    col = 0; i_bit_valid = 1'b1; i_bit_data = '0;
    clr_stats();
    tick();
    i_cmd_valid = 1'b0;
    chk("inst_bit_ready_1cyc", 64'(o_bit_ready), 64'h1);
    while (done_cnt == 0 && cyc < 2000) begin
      tick();
      if (hs) begin col++; i_bit_data = NIC'(col); end
    end
    i_bit_valid = 1'b0;
    chk("inst_done_seen", 64'(done_cnt), 64'd1);
    chk("inst_total_cycles", 64'(done_cyc), 64'd586);
    chk("inst_rises", 64'(rises), 64'd64);
    mis = 0;
    for (int k = 0; k < 64; k++)
      if (k >= rise_inst.size() || rise_inst[k] !== NIC'(k)) mis++;
    chk("inst_rise_data", 64'(mis), 64'd0);
    chk("inst_setup", 64'(setup_bad), 64'd0);
    chk("inst_hold", 64'(hold_bad), 64'd0);
    chk("inst_enable", 64'(en_bad), 64'd0);
    chk("inst_update_cycles", 64'(upd_hit), 64'd8);
    chk("inst_update_any", 64'(upd_any), 64'd8);
    chk("inst_update_en_low", 64'(en_upd_bad), 64'd0);
    chk("inst_update_then_done", 64'(done_cyc - upd_last), 64'd1);
    chk("inst_no_reset", 64'(rst_any), 64'd0);
    tick();
    chk("inst_done_one_cycle", 64'(o_done), 64'h0);
    chk("inst_ready_after_done", 64'(o_cmd_ready), 64'h1);

    // ---------------- WRITE_ADDR mask 1111 with 20-cycle gap after bit 5 ----------------
    addr_w = 16'h9A6C;
    i_cmd_valid = 1'b1; i_cmd_op = 2'd1; i_cmd_chip_mask = 4'b1111;
    exp_mask = 4'b1111; exp_en_inst = 4'b0; exp_en_addr = 4'b1111;
    taken = 0; gap = 0; i_bit_valid = 1'b1; i_bit_data = {7'h2A, addr_w[0]};
    clr_stats();
    tick();
    i_cmd_valid = 1'b0;
    while (done_cnt == 0 && cyc < 2000) begin
      tick();
      if (gap > 0) begin
        gap--;
        if (gap == 0) begin i_bit_valid = 1'b1; i_bit_data = {7'h15, addr_w[6]}; end
      end else if (hs) begin
        taken++;
        if (taken == 6) begin
          i_bit_valid = 1'b0; gap = 20; i_bit_data = {7'h2A, ~addr_w[6]};
        end else if (taken < 16) begin
          i_bit_data = {7'h2A, addr_w[taken]};
        end
      end
    end
    i_bit_valid = 1'b0;
    chk("addr_done_seen", 64'(done_cnt), 64'd1);
    chk("addr_total_cycles", 64'(done_cyc), 64'd166);
    chk("addr_rises", 64'(rises), 64'd16);
    mis = 0;
    for (int k = 0; k < 16; k++)
      if (k >= rise_addr.size() || rise_addr[k] !== addr_w[k]) mis++;
    chk("addr_rise_data", 64'(mis), 64'd0);
    chk("addr_bit6_after_gap", 64'(rise_addr.size() > 6 ? rise_addr[6] : 1'bx), 64'(addr_w[6]));
    chk("addr_stall_cycles", 64'(stall_cyc), 64'd12);
    chk("addr_gap_clk_low", 64'(gap_clk_bad), 64'd0);
    chk("addr_gap_en_held", 64'(stall_en_bad), 64'd0);
    chk("addr_enable", 64'(en_bad), 64'd0);
    chk("addr_setup_hold", 64'(setup_bad + hold_bad), 64'd0);
    chk("addr_update_cycles", 64'(upd_hit), 64'd8);
    chk("addr_inst_lines_held", 64'(o_scan_in_inst), 64'h3F);
    tick();

    // ---------------- RESET mask 0010, NOP queued while busy ----------------
    i_cmd_valid = 1'b1; i_cmd_op = 2'd0; i_cmd_chip_mask = 4'b0010;
    exp_mask = 4'b0010; exp_en_inst = 4'b0; exp_en_addr = 4'b0;
    clr_stats();
    tick();
    i_cmd_op = 2'd3; i_cmd_chip_mask = 4'b1111;
    while (done_cnt == 0 && cyc < 2000) tick();
    chk("rst_done_cycle", 64'(done_cyc), 64'd18);
    chk("rst_reset_cycles", 64'(rst_hit), 64'd16);
    chk("rst_reset_any", 64'(rst_any), 64'd16);
    chk("rst_no_scan_clk", 64'(rises), 64'd0);
    chk("busy_blocks_ready", 64'(busy_ready), 64'd0);
    tick();
    chk("queued_ready_after_done", 64'(o_cmd_ready), 64'h1);
    tick();
    chk("nop_done", 64'(o_done), 64'h1);
    chk("nop_no_pins", 64'({o_scan_clk, o_scan_reset, o_scan_update, o_scan_en_inst,
                             o_scan_en_address, o_bit_ready}), 64'h0);
    i_cmd_valid = 1'b0;
    tick();
    chk("nop_back_idle", 64'({o_done, o_busy, o_cmd_ready}), 64'h1);

    // mask 0 with a write op: straight to DONE
    i_cmd_valid = 1'b1; i_cmd_op = 2'd2; i_cmd_chip_mask = 4'b0;
    tick();
    i_cmd_valid = 1'b0;
    chk("mask0_done", 64'(o_done), 64'h1);
    chk("mask0_no_pins", 64'({o_scan_clk, o_scan_reset, o_scan_update, o_scan_en_inst,
                               o_scan_en_address, o_bit_ready}), 64'h0);
    tick();
    chk("mask0_back_idle", 64'({o_done, o_busy, o_cmd_ready}), 64'h1);

    // ---------------- reset during HI of bit 10 ----------------
    i_cmd_valid = 1'b1; i_cmd_op = 2'd2; i_cmd_chip_mask = 4'b1010;
    exp_mask = 4'b1010; exp_en_inst = 4'b1010; exp_en_addr = 4'b0;
    col = 0; i_bit_valid = 1'b1; i_bit_data = 8'hC0;
    clr_stats();
    tick();
    i_cmd_valid = 1'b0;
    while (rises < 11 && cyc < 2000) begin
      tick();
      if (hs) begin col++; i_bit_data = 8'hC0 | NIC'(col); end
    end
    chk("bit10_hi_clk", 64'(o_scan_clk), 64'h1);
    chk("bit10_hi_data", 64'(o_scan_in_inst), 64'hCA);
    i_rst = 1'b1; i_bit_valid = 1'b0;
    tick();
    chk("midrst_pins", 64'(pins()), 64'h0);
    chk("midrst_no_update", 64'(upd_any), 64'd0);
    i_rst = 1'b0;
    tick();
    chk("midrst_ready", 64'(o_cmd_ready), 64'h1);

    // follow-on WRITE_ADDR mask 0001, no stall
    addr_w = 16'h1234;
    i_cmd_valid = 1'b1; i_cmd_op = 2'd1; i_cmd_chip_mask = 4'b0001;
    exp_mask = 4'b0001; exp_en_inst = 4'b0; exp_en_addr = 4'b0001;
    taken = 0; i_bit_valid = 1'b1; i_bit_data = {7'h00, addr_w[0]};
    clr_stats();
    tick();
    i_cmd_valid = 1'b0;
    while (done_cnt == 0 && cyc < 2000) begin
      tick();
      if (hs) begin
        taken++;
        if (taken < 16) i_bit_data = {7'h00, addr_w[taken]};
      end
    end
    i_bit_valid = 1'b0;
    chk("post_total_cycles", 64'(done_cyc), 64'd154);
    chk("post_rises", 64'(rises), 64'd16);
    mis = 0;
    for (int k = 0; k < 16; k++)
      if (k >= rise_addr.size() || rise_addr[k] !== addr_w[k]) mis++;
    chk("post_rise_data", 64'(mis), 64'd0);
    chk("post_update_cycles", 64'(upd_hit), 64'd8);
    chk("post_enable", 64'(en_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
